ws2811_byte_receiver: RTL and testbench

Receives a WS2811 serial line, classifies each high pulse as a 0 or 1 bit by width, and assembles the bits MSB-first into bytes. Each byte is presented with a valid strobe and its index within the frame. The reset/latch gap is reported as frame end. The block sits at the satellite's WS2811 input, is clocked by `masterClk` from the internal OSCH oscillator, and feeds byte-oriented logic such as register shadows and LED/servo demultiplexers.

---
 rtl/ws2811_byte_receiver.sv | 221 ++++++++++++++++++++++
 tb/tb_ws2811_byte_receiver.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2811_byte_receiver.sv
// WS2811 line receiver: classifies high-pulse widths into bits and assembles MSB-first bytes.
// Reports each byte with its frame index, a clean reset gap as frame end, and timing errors.
module ws2811_byte_receiver #(
    parameter int unsigned GLITCH_MIN = 3,
    parameter int unsigned BIT_THRESH = 12,
    parameter int unsigned HIGH_MAX   = 27,
    parameter int unsigned RESET_LOW  = 1330,
    parameter int unsigned CNT_W      = 12
) (
    input  logic       masterClk,
    input  logic       nReset,
    input  logic       ws2811In,
    output logic [7:0] dataOut,
    output logic       dataValid,
    output logic [7:0] byteIdx,
    output logic       frameEnd,
    output logic       frameErr,
    output logic       active
);
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned BCNT_W = 3;

    localparam logic [2:0] S_SYNC  = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_HIGH  = 3'd2;
    localparam logic [2:0] S_LOW   = 3'd3;
    localparam logic [2:0] S_ERROR = 3'd4;

    localparam logic [CNT_W-1:0]  C_CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  C_GLITCH   = CNT_W'(GLITCH_MIN);
    localparam logic [CNT_W-1:0]  C_THRESH   = CNT_W'(BIT_THRESH);
    localparam logic [CNT_W-1:0]  C_HIGH_MAX = CNT_W'(HIGH_MAX);
    localparam logic [CNT_W-1:0]  C_RESET    = CNT_W'(RESET_LOW);
    localparam logic [BCNT_W-1:0] C_LAST_BIT = BCNT_W'(7);
    localparam logic [BYTE_W-1:0] C_IDX_MAX  = '1;

    logic              r_sync1, r_sync2, r_line_d;
    logic              w_line, w_rise, w_fall;

    logic [2:0]        r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [BYTE_W-1:0] r_shift, w_shift_nxt, w_new_shift;
    logic [BCNT_W-1:0] r_bit_cnt, w_bit_cnt_nxt;
    logic [BYTE_W-1:0] r_idx, w_idx_nxt;
    logic              r_got_bit, w_got_bit_nxt;
    logic              r_byte_seen, w_byte_seen_nxt;

    logic [BYTE_W-1:0] r_data, w_data_nxt;
    logic [BYTE_W-1:0] r_byte_idx, w_byte_idx_nxt;
    logic              r_valid, w_valid_nxt;
    logic              r_end, w_end_nxt;
    logic              r_err, w_err_nxt;
    logic              r_active, w_active_nxt;

    // Two-flop synchronizer plus a delayed copy for edge detection
    always_ff @(posedge masterClk or negedge nReset) begin
        if (!nReset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_line_d <= 1'b0;
        end else begin
            r_sync1  <= ws2811In;
            r_sync2  <= r_sync1;
            r_line_d <= r_sync2;
        end
    end

    assign w_line      = r_sync2;
    assign w_rise      = r_sync2 & ~r_line_d;
    assign w_fall      = ~r_sync2 & r_line_d;
    assign w_cnt_inc   = (r_cnt == C_CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_new_shift = {r_shift[BYTE_W-2:0], (w_cnt_inc >= C_THRESH)};

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_shift_nxt     = r_shift;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_idx_nxt       = r_idx;
        w_got_bit_nxt   = r_got_bit;
        w_byte_seen_nxt = r_byte_seen;
        w_data_nxt      = r_data;
        w_byte_idx_nxt  = r_byte_idx;
        w_valid_nxt     = 1'b0;
        w_end_nxt       = 1'b0;
        w_err_nxt       = 1'b0;
        w_active_nxt    = r_active;

        case (r_state)
            // Both wait for an unbroken low gap; any high level restarts the count
            S_SYNC, S_ERROR: begin
                if (w_line) begin
                    w_cnt_nxt = '0;
                end else if (w_cnt_inc >= C_RESET) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end

            S_IDLE: begin
                if (w_rise) begin
                    w_cnt_nxt    = '0;
                    w_active_nxt = 1'b1;
                    w_state_nxt  = S_HIGH;
                end
            end

            S_HIGH: begin
                if (w_fall) begin
                    w_cnt_nxt = '0;
                    if (w_cnt_inc < C_GLITCH) begin
                        if (r_got_bit) begin
                            w_state_nxt = S_LOW;
                        end else begin
                            w_active_nxt = 1'b0;
                            w_state_nxt  = S_IDLE;
                        end
                    end else begin
                        w_got_bit_nxt = 1'b1;
                        w_shift_nxt   = w_new_shift;
                        w_state_nxt   = S_LOW;
                        if (r_bit_cnt == C_LAST_BIT) begin
                            w_data_nxt      = w_new_shift;
                            w_valid_nxt     = 1'b1;
                            w_byte_idx_nxt  = r_idx;
                            w_idx_nxt       = (r_idx == C_IDX_MAX) ? r_idx : r_idx + BYTE_W'(1);
                            w_bit_cnt_nxt   = '0;
                            w_byte_seen_nxt = 1'b1;
                        end else begin
                            w_bit_cnt_nxt = r_bit_cnt + BCNT_W'(1);
                        end
                    end
                end else if (w_cnt_inc > C_HIGH_MAX) begin
                    w_err_nxt       = 1'b1;
                    w_active_nxt    = 1'b0;
                    w_cnt_nxt       = '0;
                    w_bit_cnt_nxt   = '0;
                    w_idx_nxt       = '0;
                    w_byte_idx_nxt  = '0;
                    w_got_bit_nxt   = 1'b0;
                    w_byte_seen_nxt = 1'b0;
                    w_state_nxt     = S_ERROR;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end

            S_LOW: begin
                if (w_rise) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_HIGH;
                end else if (w_cnt_inc >= C_RESET) begin
                    // Gap closes the frame: a leftover partial byte is an error
                    if (r_bit_cnt != '0) begin
                        w_err_nxt = 1'b1;
                    end else if (r_byte_seen) begin
                        w_end_nxt = 1'b1;
                    end
                    w_active_nxt    = 1'b0;
                    w_cnt_nxt       = '0;
                    w_bit_cnt_nxt   = '0;
                    w_shift_nxt     = '0;
                    w_idx_nxt       = '0;
                    w_byte_idx_nxt  = '0;
                    w_got_bit_nxt   = 1'b0;
                    w_byte_seen_nxt = 1'b0;
                    w_state_nxt     = S_IDLE;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end

            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_SYNC;
            end
        endcase
    end

    always_ff @(posedge masterClk or negedge nReset) begin
        if (!nReset) begin
            r_state     <= S_SYNC;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_idx       <= '0;
            r_got_bit   <= 1'b0;
            r_byte_seen <= 1'b0;
            r_data      <= '0;
            r_byte_idx  <= '0;
            r_valid     <= 1'b0;
            r_end       <= 1'b0;
            r_err       <= 1'b0;
            r_active    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_got_bit   <= w_got_bit_nxt;
            r_byte_seen <= w_byte_seen_nxt;
            r_data      <= w_data_nxt;
            r_byte_idx  <= w_byte_idx_nxt;
            r_valid     <= w_valid_nxt;
            r_end       <= w_end_nxt;
            r_err       <= w_err_nxt;
            r_active    <= w_active_nxt;
        end
    end

    assign dataOut   = r_data;
    assign dataValid = r_valid;
    assign byteIdx   = r_byte_idx;
    assign frameEnd  = r_end;
    assign frameErr  = r_err;
    assign active    = r_active;

endmodule

// File: tb/tb_ws2811_byte_receiver.sv
// Randomized self-checking bench for ws2811_byte_receiver; line is driven in masterClk units
// (37.6 ns nominal: T0H 7, T1H 16, bit period 33 cycles, 60 us gap 1600 cycles).
module tb_ws2811_byte_receiver;
    localparam int RESET_LOW = 1330;
    localparam int HIGH_MAX  = 27;
    localparam int GAP       = 1600;
    localparam int T0H       = 7;
    localparam int T1H       = 16;
    localparam int TBIT      = 33;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       ws    = 1'b0;
    logic [7:0] dataOut, byteIdx;
    logic       dataValid, frameEnd, frameErr, active;

    ws2811_byte_receiver dut (
        .masterClk (clk),
        .nReset    (rst_n),
        .ws2811In  (ws),
        .dataOut   (dataOut),
        .dataValid (dataValid),
        .byteIdx   (byteIdx),
        .frameEnd  (frameEnd),
        .frameErr  (frameErr),
        .active    (active)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Event monitor, sampled on the falling edge
    int         cyc = 0;
    logic [7:0] mon_data[$];
    logic [7:0] mon_idx[$];
    int         n_end = 0, n_err = 0, n_overlap = 0;
    int         last_end_cyc = 0, last_err_cyc = 0;
    int         last_fall_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dataValid) begin
            mon_data.push_back(dataOut);
            mon_idx.push_back(byteIdx);
        end
        if (frameEnd) begin
            n_end++;
            last_end_cyc = cyc;
        end
        if (frameErr) begin
            n_err++;
            last_err_cyc = cyc;
        end
        if ((dataValid && (frameEnd || frameErr)) || (frameEnd && frameErr)) n_overlap++;
    end

    // Reference model: bits grouped eight at a time, first bit weighted 128
    bit         m_bits[$];
    logic [7:0] e_data[$];
    int         e_end, e_err;

    task automatic model_frame();
        int v, n;
        e_data.delete();
        v = 0;
        n = 0;
        foreach (m_bits[i]) begin
            v = v * 2 + int'(m_bits[i]);
            n++;
            if (n == 8) begin
                e_data.push_back(8'(v));
                v = 0;
                n = 0;
            end
        end
        e_err = (n != 0) ? 1 : 0;
        e_end = (n == 0 && e_data.size() > 0) ? 1 : 0;
    endtask

    task automatic add_byte(input logic [7:0] b);
        for (int k = 7; k >= 0; k--) m_bits.push_back(b[k]);
    endtask

    task automatic drive_low(input int n);
        ws = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input bit b, input int skew_max, input bit fast);
        int h, s;
        s = (skew_max == 0) ? 0 : int'($urandom_range(2 * skew_max)) - skew_max;
        h = fast ? (b ? 13 : 4) : (b ? T1H : T0H) + s;
        ws = 1'b1;
        repeat (h) @(negedge clk);
        ws = 1'b0;
        last_fall_cyc = cyc;
        repeat (fast ? 3 : TBIT - h) @(negedge clk);
    endtask

    task automatic send_all(input int skew_max, input bit fast);
        foreach (m_bits[i]) send_bit(m_bits[i], skew_max, fast);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ws = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({dataOut, byteIdx} !== 16'h0000) $display("FAIL reset_data_idx: got %h/%h want 00/00", dataOut, byteIdx);
        else n_pass++;
        n_total++;
        if ({dataValid, frameEnd, frameErr, active} !== 4'b0000)
            $display("FAIL reset_strobes: got v%b e%b x%b a%b want all 0", dataValid, frameEnd, frameErr, active);
        else n_pass++;
        rst_n = 1'b1;
        drive_low(GAP);
    endtask

    task automatic test_bytes(input string name, input int skew_max, input bit rnd);
        int s_dv, s_end, s_err;
        m_bits.delete();
        if (rnd) for (int j = 0; j < 5; j++) add_byte(8'($urandom));
        else begin
            add_byte(8'h55); add_byte(8'hAA); add_byte(8'h00); add_byte(8'hFF);
        end
        model_frame();
        s_dv = mon_data.size(); s_end = n_end; s_err = n_err;
        send_bit(m_bits[0], skew_max, 1'b0);
        n_total++;
        if (active !== 1'b1) $display("FAIL %s_active_start: got %b want 1", name, active);
        else n_pass++;
        for (int i = 1; i < m_bits.size(); i++) send_bit(m_bits[i], skew_max, 1'b0);
        n_total++;
        if (active !== 1'b1) $display("FAIL %s_active_end: got %b want 1", name, active);
        else n_pass++;
        drive_low(GAP);
        n_total++;
        if (mon_data.size() - s_dv != e_data.size())
            $display("FAIL %s_count: got %0d want %0d", name, mon_data.size() - s_dv, e_data.size());
        else n_pass++;
        for (int j = 0; j < e_data.size() && s_dv + j < mon_data.size(); j++) begin
            n_total++;
            if ({mon_idx[s_dv+j], mon_data[s_dv+j]} !== {8'(j), e_data[j]})
                $display("FAIL %s_byte%0d: got idx %0d data %h want idx %0d data %h",
                         name, j, mon_idx[s_dv+j], mon_data[s_dv+j], j, e_data[j]);
            else n_pass++;
        end
        n_total++;
        if ((n_end - s_end) != 1 || (n_err - s_err) != 0)
            $display("FAIL %s_frame_end: got end %0d err %0d want end 1 err 0", name, n_end - s_end, n_err - s_err);
        else n_pass++;
        n_total++;
        if (last_end_cyc - last_fall_cyc < RESET_LOW + 2 || last_end_cyc - last_fall_cyc > RESET_LOW + 4)
            $display("FAIL %s_end_timing: got %0d cycles want %0d", name, last_end_cyc - last_fall_cyc, RESET_LOW + 3);
        else n_pass++;
        n_total++;
        if (active !== 1'b0) $display("FAIL %s_active_after: got %b want 0", name, active);
        else n_pass++;
    endtask

    task automatic test_partial_byte();
        int s_dv, s_end, s_err;
        m_bits.delete();
        add_byte(8'hA5);
        m_bits.push_back(1'b1); m_bits.push_back(1'b0); m_bits.push_back(1'b1); m_bits.push_back(1'b0);
        model_frame();
        s_dv = mon_data.size(); s_end = n_end; s_err = n_err;
        send_all(0, 1'b0);
        drive_low(GAP);
        n_total++;
        if (mon_data.size() - s_dv != 1 || mon_data[mon_data.size()-1] !== e_data[0])
            $display("FAIL partial_byte: got %0d bytes last %h want 1 byte %h",
                     mon_data.size() - s_dv, mon_data[mon_data.size()-1], e_data[0]);
        else n_pass++;
        n_total++;
        if ((n_err - s_err) != e_err || (n_end - s_end) != e_end)
            $display("FAIL partial_flags: got err %0d end %0d want err %0d end %0d",
                     n_err - s_err, n_end - s_end, e_err, e_end);
        else n_pass++;
        n_total++;
        if (byteIdx !== 8'd0 || active !== 1'b0)
            $display("FAIL partial_idx_after: got idx %0d active %b want 0/0", byteIdx, active);
        else n_pass++;
    endtask

    task automatic test_long_high();
        int s_dv, s_end, s_err, rise_cyc;
        logic [7:0] b0;
        b0 = 8'($urandom);
        m_bits.delete();
        add_byte(b0);
        m_bits.push_back(1'b1); m_bits.push_back(1'b0); m_bits.push_back(1'b1);
        s_dv = mon_data.size(); s_end = n_end; s_err = n_err;
        send_all(0, 1'b0);
        ws = 1'b1;
        rise_cyc = cyc;
        repeat (53) @(negedge clk);
        ws = 1'b0;
        n_total++;
        if ((n_err - s_err) != 1) $display("FAIL long_high_err: got %0d strobes want 1", n_err - s_err);
        else n_pass++;
        n_total++;
        if (last_err_cyc - rise_cyc < HIGH_MAX + 3 || last_err_cyc - rise_cyc > HIGH_MAX + 5)
            $display("FAIL long_high_timing: got %0d cycles after pin rise want %0d", last_err_cyc - rise_cyc, HIGH_MAX + 4);
        else n_pass++;
        n_total++;
        if (active !== 1'b0) $display("FAIL long_high_active: got %b want 0", active);
        else n_pass++;
        m_bits.delete();
        add_byte(8'($urandom));
        send_all(0, 1'b0);
        drive_low(GAP);
        n_total++;
        if (mon_data.size() - s_dv != 1 || (n_end - s_end) != 0 || (n_err - s_err) != 1)
            $display("FAIL long_high_ignored: got bytes %0d end %0d err %0d want 1/0/1",
                     mon_data.size() - s_dv, n_end - s_end, n_err - s_err);
        else n_pass++;
        test_bytes("after_err", 0, 1'b1);
    endtask

    task automatic test_sync_and_glitch();
        int s_dv, s_end, s_err;
        logic [7:0] b;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        s_dv = mon_data.size(); s_end = n_end; s_err = n_err;
        m_bits.delete();
        for (int i = 0; i < 20; i++) m_bits.push_back(1'($urandom));
        send_all(0, 1'b0);
        n_total++;
        if (mon_data.size() != s_dv || n_end != s_end || n_err != s_err || active !== 1'b0)
            $display("FAIL sync_silent: got bytes %0d end %0d err %0d active %b want 0/0/0/0",
                     mon_data.size() - s_dv, n_end - s_end, n_err - s_err, active);
        else n_pass++;
        drive_low(GAP);
        b = 8'($urandom);
        m_bits.delete();
        add_byte(b);
        model_frame();
        s_dv = mon_data.size(); s_end = n_end; s_err = n_err;
        for (int i = 0; i < 8; i++) begin
            send_bit(m_bits[i], 0, 1'b0);
            if (i == 3) begin
                ws = 1'b1;
                repeat (2) @(negedge clk);
                ws = 1'b0;
                repeat (10) @(negedge clk);
            end
        end
        drive_low(GAP);
        n_total++;
        if (mon_data.size() - s_dv != 1 || {mon_idx[mon_idx.size()-1], mon_data[mon_data.size()-1]} !== {8'd0, e_data[0]})
            $display("FAIL glitch_byte: got %0d bytes last idx %0d data %h want 1 byte idx 0 data %h",
                     mon_data.size() - s_dv, mon_idx[mon_idx.size()-1], mon_data[mon_data.size()-1], e_data[0]);
        else n_pass++;
        n_total++;
        if ((n_end - s_end) != 1 || (n_err - s_err) != 0)
            $display("FAIL glitch_flags: got end %0d err %0d want 1/0", n_end - s_end, n_err - s_err);
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        m_bits.delete();
        add_byte(8'h3C); add_byte(8'h81);
        m_bits.push_back(1'b1); m_bits.push_back(1'b1); m_bits.push_back(1'b0); m_bits.push_back(1'b1);
        send_all(0, 1'b0);
        n_total++;
        if ({dataOut, byteIdx, active} !== {8'h81, 8'd1, 1'b1})
            $display("FAIL premid_state: got %h/%0d/%b want 81/1/1", dataOut, byteIdx, active);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({dataOut, byteIdx, dataValid, frameEnd, frameErr, active} !== 20'h0)
            $display("FAIL mid_reset: got data %h idx %0d v%b e%b x%b a%b want all 0",
                     dataOut, byteIdx, dataValid, frameEnd, frameErr, active);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        drive_low(GAP);
        test_bytes("post_reset", 4, 1'b1);
    endtask

    task automatic test_back_to_back();
        int s_dv, bad;
        m_bits.delete();
        for (int j = 0; j < 258; j++) add_byte(8'($urandom));
        model_frame();
        s_dv = mon_data.size();
        send_all(0, 1'b1);
        drive_low(GAP);
        n_total++;
        if (mon_data.size() - s_dv != 258) $display("FAIL b2b_count: got %0d want 258", mon_data.size() - s_dv);
        else n_pass++;
        bad = 0;
        for (int j = 0; j < 258 && s_dv + j < mon_data.size(); j++)
            if ({mon_idx[s_dv+j], mon_data[s_dv+j]} !== {8'((j > 255) ? 255 : j), e_data[j]}) bad++;
        n_total++;
        if (bad != 0) $display("FAIL b2b_bytes: got %0d wrong bytes want 0", bad);
        else n_pass++;
        n_total++;
        if (mon_idx[mon_idx.size()-1] !== 8'd255 || mon_idx[mon_idx.size()-2] !== 8'd255)
            $display("FAIL b2b_saturate: got last idx %0d,%0d want 255,255",
                     mon_idx[mon_idx.size()-2], mon_idx[mon_idx.size()-1]);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_bytes("nominal", 0, 1'b0);
        test_bytes("skew", 4, 1'b0);
        test_bytes("skew_rand", 4, 1'b1);
        test_partial_byte();
        test_long_high();
        test_sync_and_glitch();
        test_reset_mid_frame();
        test_back_to_back();
        n_total++;
        if (n_overlap != 0) $display("FAIL strobe_overlap: got %0d cycles want 0", n_overlap);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
